// File: rtl/pong_match_controller.sv
// ---------------------------------------------------------------------------
// pong_match_controller
//
// Match sequencer for Pong. Decides when play runs, when the ball is
// re-served, keeps both scores and declares the winner. Ball, paddles and
// score display are gated by o_run and o_ball_reset.
//
// Optional feature macro: PONG_PAUSE_EN
//   defined     -> PAUSE state (encoding 4) and PAUSE_KEY handling present
//   not defined -> PAUSE_KEY ignored everywhere, encoding 4 is unused
//
// Parameters:
//   WIN_SCORE   (1..15)  points needed to win
//   SERVE_DELAY (0..255) frame ticks spent in SERVE before play resumes
//   START_KEY            byte that starts / restarts a match
//   PAUSE_KEY            byte that toggles pause
//
// Ports:
//   i_CLK         system clock (single domain)
//   i_RST_N       synchronous active-low reset
//   i_frame_tick  one-cycle pulse per game-engine tick
//   i_key_valid   one-cycle strobe qualifying i_key_byte
//   i_key_byte    received key code
//   i_p1_scored   one-cycle pulse, player 1 won the rally
//   i_p2_scored   one-cycle pulse, player 2 won the rally
//   o_run         enables ball and paddle motion
//   o_ball_reset  one-cycle pulse, first cycle of every SERVE
//   o_serve_dir   0 = toward player 1 (left), 1 = toward player 2 (right)
//   o_p1_score    player 1 score
//   o_p2_score    player 2 score
//   o_winner      0 none, 1 player 1, 2 player 2
//   o_state       current state encoding (debug / display)
//
// Input strobe semantics: i_key_valid, i_frame_tick and the scored pulses
// carry no backpressure. Each is consumed only in the cycle it is high; a
// strobe arriving in a state that does not use it is dropped, not queued.
// All outputs are registered: they change on the edge after the input.
// ---------------------------------------------------------------------------
module pong_match_controller #(
    parameter int WIN_SCORE   = 7,
    parameter int SERVE_DELAY = 60,
    parameter int START_KEY   = 32,
    parameter int PAUSE_KEY   = 112
) (
    input  logic       i_CLK,
    input  logic       i_RST_N,
    input  logic       i_frame_tick,
    input  logic       i_key_valid,
    input  logic [7:0] i_key_byte,
    input  logic       i_p1_scored,
    input  logic       i_p2_scored,
    output logic       o_run,
    output logic       o_ball_reset,
    output logic       o_serve_dir,
    output logic [3:0] o_p1_score,
    output logic [3:0] o_p2_score,
    output logic [1:0] o_winner,
    output logic [2:0] o_state
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_SERVE     = 3'd1;
    localparam logic [2:0] S_PLAY      = 3'd2;
    localparam logic [2:0] S_POINT     = 3'd3;
    localparam logic [2:0] S_PAUSE     = 3'd4;
    localparam logic [2:0] S_GAME_OVER = 3'd5;

    localparam logic [3:0] WIN_VAL   = 4'(WIN_SCORE);
    localparam logic [8:0] DELAY_VAL = 9'(SERVE_DELAY);
    localparam logic [7:0] START_VAL = 8'(START_KEY);
    localparam logic [7:0] PAUSE_VAL = 8'(PAUSE_KEY);

    logic [2:0] state, state_d;
    logic [7:0] tick_cnt, tick_cnt_d;
    logic       scorer_p2, scorer_p2_d;   // 1 when player 2 won the last rally
    logic       run_d, ball_reset_d, serve_dir_d;
    logic [3:0] p1_score_d, p2_score_d;
    logic [1:0] winner_d;

    logic       key_start;
    logic       key_pause;
    logic       serve_done;
    logic       both_scored;
    logic       one_scored;
    logic [3:0] scorer_score;

    assign key_start   = i_key_valid && (i_key_byte == START_VAL);
    // Without the pause feature the pause byte is just another ignored key.
`ifdef PONG_PAUSE_EN
    assign key_pause   = i_key_valid && (i_key_byte == PAUSE_VAL);
`else
    assign key_pause   = 1'b0 && (PAUSE_VAL == i_key_byte);
`endif
    assign both_scored = i_p1_scored && i_p2_scored;
    assign one_scored  = i_p1_scored ^ i_p2_scored;
    assign scorer_score = scorer_p2 ? o_p2_score : o_p1_score;

    // A zero delay leaves SERVE unconditionally on the cycle after entry;
    // otherwise leave on the tick that brings the count to SERVE_DELAY.
    assign serve_done = (DELAY_VAL == 9'd0) ||
                        (i_frame_tick && (({1'b0, tick_cnt} + 9'd1) >= DELAY_VAL));

    // ---------------------------------------------------------------- state register
    always_ff @(posedge i_CLK) begin
        if (!i_RST_N) begin
            state        <= S_IDLE;
            tick_cnt     <= 8'd0;
            scorer_p2    <= 1'b0;
            o_run        <= 1'b0;
            o_ball_reset <= 1'b0;
            o_serve_dir  <= 1'b0;
            o_p1_score   <= 4'd0;
            o_p2_score   <= 4'd0;
            o_winner     <= 2'd0;
        end else begin
            state        <= state_d;
            tick_cnt     <= tick_cnt_d;
            scorer_p2    <= scorer_p2_d;
            o_run        <= run_d;
            o_ball_reset <= ball_reset_d;
            o_serve_dir  <= serve_dir_d;
            o_p1_score   <= p1_score_d;
            o_p2_score   <= p2_score_d;
            o_winner     <= winner_d;
        end
    end

    assign o_state = state;

    // ---------------------------------------------------------------- next state
    always_comb begin
        state_d = state;
        case (state)
            S_IDLE, S_GAME_OVER: begin
                if (key_start) state_d = S_SERVE;
            end
            S_SERVE: begin
                if (serve_done) state_d = S_PLAY;
            end
            S_PLAY: begin
                // Scored pulses outrank the pause key in the same cycle.
                if (both_scored)     state_d = S_SERVE;
                else if (one_scored) state_d = S_POINT;
                else if (key_pause)  state_d = S_PAUSE;
            end
            S_POINT: begin
                state_d = (scorer_score == WIN_VAL) ? S_GAME_OVER : S_SERVE;
            end
`ifdef PONG_PAUSE_EN
            S_PAUSE: begin
                if (key_pause) state_d = S_PLAY;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------------- next outputs
    always_comb begin
        run_d        = (state_d == S_PLAY);
        ball_reset_d = 1'b0;
        serve_dir_d  = o_serve_dir;
        p1_score_d   = o_p1_score;
        p2_score_d   = o_p2_score;
        winner_d     = o_winner;
        tick_cnt_d   = tick_cnt;
        scorer_p2_d  = scorer_p2;
        case (state)
            S_IDLE, S_GAME_OVER: begin
                if (key_start) begin
                    p1_score_d   = 4'd0;
                    p2_score_d   = 4'd0;
                    winner_d     = 2'd0;
                    serve_dir_d  = 1'b0;
                    ball_reset_d = 1'b1;
                    tick_cnt_d   = 8'd0;
                end
            end
            S_SERVE: begin
                if (serve_done)        tick_cnt_d = 8'd0;
                else if (i_frame_tick) tick_cnt_d = tick_cnt + 8'd1;
            end
            S_PLAY: begin
                if (both_scored) begin
                    // Void rally: re-serve in the same direction.
                    ball_reset_d = 1'b1;
                    tick_cnt_d   = 8'd0;
                end else if (i_p1_scored) begin
                    p1_score_d  = o_p1_score + 4'd1;
                    scorer_p2_d = 1'b0;
                end else if (i_p2_scored) begin
                    p2_score_d  = o_p2_score + 4'd1;
                    scorer_p2_d = 1'b1;
                end
            end
            S_POINT: begin
                if (scorer_score == WIN_VAL) begin
                    winner_d = scorer_p2 ? 2'd2 : 2'd1;
                end else begin
                    // Serve toward the player who conceded the point.
                    serve_dir_d  = ~scorer_p2;
                    ball_reset_d = 1'b1;
                    tick_cnt_d   = 8'd0;
                end
            end
`ifdef PONG_PAUSE_EN
            S_PAUSE: begin
                // Ball position is frozen, nothing else changes.
            end
`endif
            default: begin
                // Unused encodings fall back to reset values.
                run_d        = 1'b0;
                serve_dir_d  = 1'b0;
                p1_score_d   = 4'd0;
                p2_score_d   = 4'd0;
                winner_d     = 2'd0;
                tick_cnt_d   = 8'd0;
                scorer_p2_d  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_pong_match_controller.sv
// ---------------------------------------------------------------------------
// tb_pong_match_controller
//
// Directed scenario tasks with inline checks, followed by a randomized run
// compared every cycle against a behavioural match model. DUT is built with
// WIN_SCORE = 3 and SERVE_DELAY = 3 so games finish quickly.
// ---------------------------------------------------------------------------
module tb_pong_match_controller;

    localparam int WIN = 3;
    localparam int SD  = 3;
    localparam logic [7:0] K_START = 8'd32;
    localparam logic [7:0] K_PAUSE = 8'd112;
`ifdef PONG_PAUSE_EN
    localparam bit PAUSE_EN = 1'b1;
`else
    localparam bit PAUSE_EN = 1'b0;
`endif

    // ---------------------------------------------------------------- clock / reset
    logic       clk = 1'b0;
    logic       i_RST_N = 1'b0;
    logic       i_frame_tick = 1'b0;
    logic       i_key_valid = 1'b0;
    logic [7:0] i_key_byte = 8'd0;
    logic       i_p1_scored = 1'b0;
    logic       i_p2_scored = 1'b0;
    logic       o_run, o_ball_reset, o_serve_dir;
    logic [3:0] o_p1_score, o_p2_score;
    logic [1:0] o_winner;
    logic [2:0] o_state;

    always #5 clk = ~clk;

    pong_match_controller #(
        .WIN_SCORE(WIN), .SERVE_DELAY(SD), .START_KEY(32), .PAUSE_KEY(112)
    ) dut (
        .i_CLK(clk), .i_RST_N(i_RST_N), .i_frame_tick(i_frame_tick),
        .i_key_valid(i_key_valid), .i_key_byte(i_key_byte),
        .i_p1_scored(i_p1_scored), .i_p2_scored(i_p2_scored),
        .o_run(o_run), .o_ball_reset(o_ball_reset), .o_serve_dir(o_serve_dir),
        .o_p1_score(o_p1_score), .o_p2_score(o_p2_score),
        .o_winner(o_winner), .o_state(o_state)
    );

    int tests = 0;
    int fails = 0;

    // ---------------------------------------------------------------- reference model
    // Match described as: mode (spec encoding), scores, winner, serve side,
    // ticks waited in the current serve and who won the last rally.
    int m_mode = 0, m_p1 = 0, m_p2 = 0, m_win = 0, m_ticks = 0, m_last = 1;
    bit m_dir = 0, m_run = 0, m_br = 0;

    task automatic model_update(input bit rst_n, input bit ft, input bit kv,
                                input logic [7:0] kb, input bit s1, input bit s2);
        bit start_k, pause_k;
        int pts;
        start_k = kv && (kb == K_START);
        pause_k = PAUSE_EN && kv && (kb == K_PAUSE);
        m_br = 0;
        if (!rst_n) begin
            m_mode = 0; m_p1 = 0; m_p2 = 0; m_win = 0; m_dir = 0; m_ticks = 0;
        end else begin
            case (m_mode)
                0, 5: if (start_k) begin
                    m_mode = 1; m_p1 = 0; m_p2 = 0; m_win = 0; m_dir = 0;
                    m_br = 1; m_ticks = 0;
                end
                1: begin
                    if (ft) m_ticks++;
                    if (m_ticks >= SD) m_mode = 2;
                end
                2: begin
                    if (s1 && s2) begin m_mode = 1; m_br = 1; m_ticks = 0; end
                    else if (s1) begin m_p1++; m_last = 1; m_mode = 3; end
                    else if (s2) begin m_p2++; m_last = 2; m_mode = 3; end
                    else if (pause_k) m_mode = 4;
                end
                3: begin
                    pts = (m_last == 1) ? m_p1 : m_p2;
                    if (pts == WIN) begin m_win = m_last; m_mode = 5; end
                    else begin
                        m_dir = (m_last == 1); m_br = 1; m_mode = 1; m_ticks = 0;
                    end
                end
                4: if (pause_k) m_mode = 2;
                default: m_mode = 0;
            endcase
        end
        m_run = (m_mode == 2);
    endtask

    // ---------------------------------------------------------------- driver tasks
    // Inputs are applied 1 time unit after a rising edge, sampled by the next
    // edge; outputs are read 1 time unit after that edge.
    task automatic step(input bit rst_n, input bit ft, input bit kv,
                        input logic [7:0] kb, input bit s1, input bit s2);
        i_RST_N = rst_n; i_frame_tick = ft; i_key_valid = kv;
        i_key_byte = kb; i_p1_scored = s1; i_p2_scored = s2;
        @(posedge clk);
        #1;
        model_update(rst_n, ft, kv, kb, s1, s2);
        i_RST_N = 1'b1; i_frame_tick = 1'b0; i_key_valid = 1'b0;
        i_key_byte = 8'd0; i_p1_scored = 1'b0; i_p2_scored = 1'b0;
    endtask

    task automatic idle();            step(1, 0, 0, 8'd0, 0, 0); endtask
    task automatic tick();            step(1, 1, 0, 8'd0, 0, 0); endtask
    task automatic key(input logic [7:0] kb); step(1, 0, 1, kb, 0, 0); endtask
    task automatic scored(input bit s1, input bit s2); step(1, 0, 0, 8'd0, s1, s2); endtask

    task automatic serve_to_play();
        for (int i = 0; i < SD; i++) tick();
    endtask

    // ---------------------------------------------------------------- scenarios
    task automatic test_reset();
        step(0, 0, 0, 8'd0, 0, 0);
        step(0, 1, 1, K_START, 1, 0);
        tests++; if (o_state !== 3'd0) begin fails++; $display("FAIL reset_state got %0d exp 0", o_state); end
        tests++; if (o_run !== 1'b0) begin fails++; $display("FAIL reset_run got %0b exp 0", o_run); end
        tests++; if (o_ball_reset !== 1'b0) begin fails++; $display("FAIL reset_ball_reset got %0b exp 0", o_ball_reset); end
        tests++; if (o_serve_dir !== 1'b0) begin fails++; $display("FAIL reset_dir got %0b exp 0", o_serve_dir); end
        tests++; if (o_p1_score !== 4'd0 || o_p2_score !== 4'd0) begin fails++; $display("FAIL reset_scores got %0d-%0d exp 0-0", o_p1_score, o_p2_score); end
        tests++; if (o_winner !== 2'd0) begin fails++; $display("FAIL reset_winner got %0d exp 0", o_winner); end
    endtask

    task automatic test_start_serve();
        key(8'd65);
        tests++; if (o_state !== 3'd0) begin fails++; $display("FAIL other_key_idle got %0d exp 0", o_state); end
        key(K_START);
        tests++; if (o_state !== 3'd1) begin fails++; $display("FAIL start_state got %0d exp 1", o_state); end
        tests++; if (o_ball_reset !== 1'b1) begin fails++; $display("FAIL start_ball_reset got %0b exp 1", o_ball_reset); end
        idle();
        tests++; if (o_ball_reset !== 1'b0) begin fails++; $display("FAIL ball_reset_width got %0b exp 0", o_ball_reset); end
        tick(); idle(); scored(1, 0); tick();
        tests++; if (o_state !== 3'd1 || o_run !== 1'b0) begin fails++; $display("FAIL serve_wait got state %0d run %0b exp 1/0", o_state, o_run); end
        tests++; if (o_p1_score !== 4'd0) begin fails++; $display("FAIL serve_ignores_score got %0d exp 0", o_p1_score); end
        tick();
        tests++; if (o_state !== 3'd2 || o_run !== 1'b1) begin fails++; $display("FAIL serve_to_play got state %0d run %0b exp 2/1", o_state, o_run); end
    endtask

    task automatic test_point();
        scored(1, 0);
        tests++; if (o_p1_score !== 4'd1 || o_state !== 3'd3 || o_run !== 1'b0) begin fails++; $display("FAIL point_p1 got score %0d state %0d run %0b exp 1/3/0", o_p1_score, o_state, o_run); end
        idle();
        tests++; if (o_state !== 3'd1 || o_serve_dir !== 1'b1 || o_ball_reset !== 1'b1) begin fails++; $display("FAIL point_reserve got state %0d dir %0b br %0b exp 1/1/1", o_state, o_serve_dir, o_ball_reset); end
        idle();
        tests++; if (o_ball_reset !== 1'b0) begin fails++; $display("FAIL point_br_width got %0b exp 0", o_ball_reset); end
        serve_to_play();
    endtask

    task automatic test_void_rally();
        scored(1, 1);
        tests++; if (o_state !== 3'd1 || o_ball_reset !== 1'b1) begin fails++; $display("FAIL void_reserve got state %0d br %0b exp 1/1", o_state, o_ball_reset); end
        tests++; if (o_p1_score !== 4'd1 || o_p2_score !== 4'd0 || o_serve_dir !== 1'b1) begin fails++; $display("FAIL void_hold got %0d-%0d dir %0b exp 1-0 dir 1", o_p1_score, o_p2_score, o_serve_dir); end
        serve_to_play();
    endtask

    task automatic test_pause();
        key(K_PAUSE);
        if (PAUSE_EN) begin
            tests++; if (o_state !== 3'd4 || o_run !== 1'b0) begin fails++; $display("FAIL pause_enter got state %0d run %0b exp 4/0", o_state, o_run); end
            scored(0, 1); key(K_START);
            tests++; if (o_state !== 3'd4 || o_p2_score !== 4'd0 || o_ball_reset !== 1'b0) begin fails++; $display("FAIL pause_ignore got state %0d p2 %0d br %0b exp 4/0/0", o_state, o_p2_score, o_ball_reset); end
            key(K_PAUSE);
            tests++; if (o_state !== 3'd2 || o_run !== 1'b1) begin fails++; $display("FAIL pause_exit got state %0d run %0b exp 2/1", o_state, o_run); end
        end else begin
            tests++; if (o_state !== 3'd2 || o_run !== 1'b1) begin fails++; $display("FAIL pause_key_ignored got state %0d run %0b exp 2/1", o_state, o_run); end
        end
        // Score beats a simultaneous pause key.
        step(1, 0, 1, K_PAUSE, 0, 1);
        tests++; if (o_state !== 3'd3 || o_p2_score !== 4'd1) begin fails++; $display("FAIL score_over_pause got state %0d p2 %0d exp 3/1", o_state, o_p2_score); end
        idle();
        tests++; if (o_serve_dir !== 1'b0) begin fails++; $display("FAIL p2_point_dir got %0b exp 0", o_serve_dir); end
        serve_to_play();
    endtask

    task automatic test_game_over();
        // Score stands 1-1; two more p2 points win at 3.
        scored(0, 1); idle(); serve_to_play();
        scored(0, 1);
        tests++; if (o_p2_score !== 4'd3 || o_state !== 3'd3) begin fails++; $display("FAIL win_point got p2 %0d state %0d exp 3/3", o_p2_score, o_state); end
        idle();
        tests++; if (o_state !== 3'd5 || o_winner !== 2'd2 || o_run !== 1'b0 || o_ball_reset !== 1'b0) begin fails++; $display("FAIL game_over got state %0d win %0d run %0b br %0b exp 5/2/0/0", o_state, o_winner, o_run, o_ball_reset); end
        scored(1, 0); scored(0, 1); tick(); key(K_PAUSE);
        tests++; if (o_p1_score !== 4'd1 || o_p2_score !== 4'd3 || o_state !== 3'd5 || o_winner !== 2'd2) begin fails++; $display("FAIL game_over_hold got %0d-%0d state %0d win %0d exp 1-3/5/2", o_p1_score, o_p2_score, o_state, o_winner); end
    endtask

    task automatic test_restart();
        key(K_START);
        tests++; if (o_state !== 3'd1 || o_ball_reset !== 1'b1 || o_winner !== 2'd0) begin fails++; $display("FAIL restart got state %0d br %0b win %0d exp 1/1/0", o_state, o_ball_reset, o_winner); end
        tests++; if (o_p1_score !== 4'd0 || o_p2_score !== 4'd0 || o_serve_dir !== 1'b0) begin fails++; $display("FAIL restart_clear got %0d-%0d dir %0b exp 0-0 dir 0", o_p1_score, o_p2_score, o_serve_dir); end
    endtask

    task automatic test_reset_in_game_over();
        serve_to_play();
        for (int i = 0; i < WIN; i++) begin
            scored(1, 0); idle();
            if (i < WIN - 1) serve_to_play();
        end
        tests++; if (o_state !== 3'd5 || o_winner !== 2'd1 || o_p1_score !== 4'd3) begin fails++; $display("FAIL p1_win got state %0d win %0d p1 %0d exp 5/1/3", o_state, o_winner, o_p1_score); end
        step(0, 0, 1, K_START, 0, 0);
        tests++; if ({o_state, o_run, o_ball_reset, o_serve_dir, o_p1_score, o_p2_score, o_winner} !== 16'd0) begin fails++; $display("FAIL reset_from_game_over got state %0d scores %0d-%0d win %0d exp all 0", o_state, o_p1_score, o_p2_score, o_winner); end
    endtask

    task automatic test_random();
        logic [7:0]  kb;
        logic [15:0] exp_v, got_v;
        bit rst_n, ft, kv, s1, s2;
        step(0, 0, 0, 8'd0, 0, 0);
        for (int c = 0; c < 4000; c++) begin
            rst_n = ($urandom_range(0, 599) != 0);
            ft    = ($urandom_range(0, 1) == 1);
            kv    = ($urandom_range(0, 5) == 0);
            case ($urandom_range(0, 3))
                0: kb = K_START;
                1: kb = K_PAUSE;
                default: kb = 8'($urandom_range(0, 255));
            endcase
            s1 = ($urandom_range(0, 7) == 0);
            s2 = ($urandom_range(0, 7) == 0);
            step(rst_n, ft, kv, kb, s1, s2);
            exp_v = {3'(m_mode), m_run, m_br, m_dir, 4'(m_p1), 4'(m_p2), 2'(m_win)};
            got_v = {o_state, o_run, o_ball_reset, o_serve_dir, o_p1_score, o_p2_score, o_winner};
            tests++;
            if (got_v !== exp_v) begin
                fails++;
                $display("FAIL random_cycle_%0d got state/run/br/dir/p1/p2/win %h exp %h", c, got_v, exp_v);
            end
        end
    endtask

    // ---------------------------------------------------------------- sequence and report
    initial begin
        test_reset();
        test_start_serve();
        test_point();
        test_void_rally();
        test_pause();
        test_game_over();
        test_restart();
        test_reset_in_game_over();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pong_match_controller.md
# pong_match_controller

Match sequencer for the Pong game. It sits between the UART key receiver, the ball physics and the paddle logic. It decides when play runs, when the ball is re-served, keeps both scores, and declares a winner. Everything downstream (ball, paddles, score display) is gated by its `o_run` and `o_ball_reset` outputs.

## Interface
Parameters:
- `WIN_SCORE`, default 7: points needed to win. Legal range 1..15.
- `SERVE_DELAY`, default 60: frame ticks spent in SERVE before play resumes. Legal range 0..255.
- `START_KEY`, default 32 (space): byte that starts or restarts a match.
- `PAUSE_KEY`, default 112 ('p'): byte that toggles pause.

Ports:
- `i_CLK`, in, 1: system clock. Single clock domain; all inputs are synchronous to it.
- `i_RST_N`, in, 1: reset, synchronous, active-low.
- `i_frame_tick`, in, 1: one-cycle pulse per game-engine tick.
- `i_key_valid`, in, 1: one-cycle strobe; `i_key_byte` is valid in that cycle.
- `i_key_byte`, in, 8: received key code.
- `i_p1_scored`, in, 1: one-cycle pulse; player 1 won the rally.
- `i_p2_scored`, in, 1: one-cycle pulse; player 2 won the rally.
- `o_run`, out, 1: enables ball and paddle motion.
- `o_ball_reset`, out, 1: one-cycle pulse that re-centres the ball.
- `o_serve_dir`, out, 1: serve direction. 0 = toward player 1 (left), 1 = toward player 2 (right).
- `o_p1_score`, out, 4: player 1 score.
- `o_p2_score`, out, 4: player 2 score.
- `o_winner`, out, 2: 0 = none, 1 = player 1, 2 = player 2.
- `o_state`, out, 3: current state encoding, for debug and display.

## Operation
- States and encodings: IDLE = 0, SERVE = 1, PLAY = 2, POINT = 3, PAUSE = 4, GAME_OVER = 5.
- Keys are acted on only in cycles where `i_key_valid` = 1. Any byte other than `START_KEY` or `PAUSE_KEY` is ignored.
- **IDLE:** on `START_KEY`:
  - go to SERVE;
  - clear both scores;
  - set `o_winner` = 0 and `o_serve_dir` = 0;
  - pulse `o_ball_reset`.
- **SERVE:**
  - `o_run` = 0;
  - the tick counter clears on entry and increments on each `i_frame_tick`;
  - when the counter reaches `SERVE_DELAY`, go to PLAY. With `SERVE_DELAY` = 0, go to PLAY on the cycle after entry.
  - Scored pulses are ignored.
- **PLAY:**
  - `o_run` = 1.
  - Exactly one scored pulse: increment that player's score and go to POINT.
  - Both pulses in the same cycle: the rally is void. Scores are unchanged, `o_serve_dir` is unchanged, pulse `o_ball_reset`, go to SERVE.
  - `PAUSE_KEY` (when the feature is compiled in): go to PAUSE. If a scored pulse arrives in the same cycle, the scored pulse takes priority and the key is dropped.
- **POINT:** one cycle, `o_run` = 0.
  - If the scorer's score equals `WIN_SCORE`: set `o_winner` to the scorer and go to GAME_OVER.
  - Otherwise: set `o_serve_dir` toward the player who conceded (p1 scored → 1, p2 scored → 0), pulse `o_ball_reset`, go to SERVE.
- **PAUSE:**
  - `o_run` = 0;
  - `PAUSE_KEY` returns to PLAY;
  - `START_KEY` and scored pulses are ignored;
  - the ball is not reset.
- **GAME_OVER:**
  - `o_run` = 0;
  - scores and `o_winner` hold;
  - `START_KEY` behaves exactly as it does in IDLE.
- Scores never exceed `WIN_SCORE`; there is no wrap-around.
- Unused state encodings (6, 7) return to IDLE on the next cycle with reset output values.

## Timing
- All outputs are registered. A state change and its outputs appear on the first `i_CLK` edge after the triggering input.
- `o_ball_reset` is high for exactly one cycle. It coincides with the first cycle of the SERVE state.
- Point to next serve: scored pulse → POINT (1 cycle) → SERVE. This gives 2 cycles from the pulse to `o_ball_reset`.
- SERVE to PLAY: `o_run` rises 1 cycle after the `SERVE_DELAY`-th tick is sampled.
- Reset: `i_RST_N` = 0 at a rising edge puts the block into this state from any state, and dominates every other input:
  - state = IDLE;
  - `o_run` = 0, `o_ball_reset` = 0, `o_serve_dir` = 0;
  - both scores = 0, `o_winner` = 0, `o_state` = 0;
  - tick counter = 0.

## Configuration
- `PONG_PAUSE_EN` defined: PAUSE state and `PAUSE_KEY` handling are present as described above.
- Not defined:
  - `PAUSE_KEY` is ignored in every state;
  - PAUSE is unreachable and its logic is not compiled;
  - encoding 4 is treated as an unused encoding.

## Test plan
- Reset, then `START_KEY`: next cycle `o_state` = 1 and `o_ball_reset` = 1 for one cycle. With `SERVE_DELAY` = 3, `o_run` = 1 one cycle after the 3rd `i_frame_tick`.
- In PLAY, pulse `i_p1_scored`: `o_p1_score` = 1, `o_state` = 3 for one cycle, then 1. `o_serve_dir` = 1 and `o_ball_reset` pulses.
- `WIN_SCORE` = 2, p2 scores twice: `o_p2_score` = 2, `o_winner` = 2, `o_state` = 5, `o_run` = 0. Further scored pulses leave the scores unchanged.
- `i_p1_scored` and `i_p2_scored` together in PLAY: scores are unchanged, `o_ball_reset` pulses, `o_state` = 1.
- With `PONG_PAUSE_EN`: `PAUSE_KEY` in PLAY gives `o_state` = 4 and `o_run` = 0. A scored pulse in PAUSE is ignored. `PAUSE_KEY` again gives `o_state` = 2. Without the macro, `PAUSE_KEY` leaves `o_state` = 2.
- Drive `i_RST_N` = 0 in GAME_OVER with scores 7–5: the next edge gives all outputs 0 and `o_state` = 0.
